led_sweep_checker: RTL and testbench

//  Monitor/decoder for the bouncing one-hot LED sweep (bit0 -> bit15 -> bit0, 30 steps/period).

---
 rtl/led_sweep_pkg.sv | 22 ++
 rtl/led_sweep_checker_onehot_encoder.sv | 22 ++
 rtl/led_sweep_checker.sv | 163 ++++++++++++++++
 tb/tb_led_sweep_checker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/led_sweep_pkg.sv
// Shared types and helpers for the LED sweep monitor.
package led_sweep_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        ERROR = 2'd3
    } sweep_state_t;

    localparam int ERR_CNT_W = 8;

    // Error counter increment that sticks at all-ones.
    function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] cnt);
        if (cnt == {ERR_CNT_W{1'b1}}) begin
            err_sat_inc = cnt;
        end else begin
            err_sat_inc = cnt + ERR_CNT_W'(1'b1);
        end
    endfunction

endpackage

// File: rtl/led_sweep_checker_onehot_encoder.sv
// Combinational one-hot detector and bit-index encoder for the LED bus.
module onehot_encoder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         vec,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     is_onehot
);

    localparam int IDX_W = $clog2(WIDTH);

    // OR of set-bit positions; exact whenever vec is one-hot, don't-care otherwise.
    always_comb begin
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            idx = idx | (vec[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
        is_onehot = (vec != {WIDTH{1'b0}}) &&
                    ((vec & (vec - WIDTH'(1'b1))) == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/led_sweep_checker.sv
// Locks onto the bouncing one-hot LED sweep and reports position, direction,
// round trips, illegal steps and stalls. All outputs are registered.
module led_sweep_checker
    import led_sweep_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int STALL_LIMIT = 1000,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [WIDTH-1:0]         pattern,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     dir,
    output logic                     locked,
    output logic [CNT_W-1:0]         sweep_count,
    output logic                     err,
    output logic [ERR_CNT_W-1:0]     err_count,
    output logic                     stalled
);

    localparam int                   POS_W     = $clog2(WIDTH);
    localparam int                   STALL_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [POS_W-1:0]     POS_MAX   = POS_W'(WIDTH - 1);
    localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(STALL_LIMIT);
    localparam logic [WIDTH-1:0]     START_PAT = WIDTH'(1'b1);

    sweep_state_t         state_q, state_d;
    logic [WIDTH-1:0]     last_q, last_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 dir_q, dir_d;
    logic                 locked_q, locked_d;
    logic [CNT_W-1:0]     sweep_q, sweep_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 stalled_q, stalled_d;

    logic [POS_W-1:0]     idx_s;
    logic                 is_onehot_s;
    logic                 changed_s;
    logic                 is_start_s;
    logic [POS_W-1:0]     pos_up_s;
    logic [POS_W-1:0]     pos_dn_s;
    logic [STALL_W-1:0]   stall_inc_s;

    onehot_encoder #(.WIDTH(WIDTH)) u_enc (
        .vec       (pattern),
        .idx       (idx_s),
        .is_onehot (is_onehot_s)
    );

    assign changed_s   = (pattern != last_q);
    assign is_start_s  = (pattern == START_PAT);
    assign pos_up_s    = pos_q + POS_W'(1'b1);
    assign pos_dn_s    = pos_q - POS_W'(1'b1);
    assign stall_inc_s = (stall_q == STALL_MAX) ? stall_q : (stall_q + STALL_W'(1'b1));

    // Next-state: track legal steps, flag illegal ones, count idle cycles while locked.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        stall_d   = stall_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        sweep_d   = sweep_q;
        err_cnt_d = err_cnt_q;
        stalled_d = stalled_q;
        if (en) begin
            last_d = pattern;
            case (state_q)
                SYNC, ERROR: begin
                    stall_d   = {STALL_W{1'b0}};
                    stalled_d = 1'b0;
                    if (is_start_s) begin
                        state_d = LEFT;
                        pos_d   = {POS_W{1'b0}};
                        dir_d   = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                LEFT, RIGHT: begin
                    if (!changed_s) begin
                        // A paused generator is never an error; it only raises stalled.
                        stall_d   = stall_inc_s;
                        stalled_d = (stall_inc_s == STALL_MAX);
                    end else if (is_onehot_s && (state_q == LEFT) && (idx_s == pos_up_s)) begin
                        pos_d     = idx_s;
                        stall_d   = {STALL_W{1'b0}};
                        stalled_d = 1'b0;
                        if (idx_s == POS_MAX) begin
                            state_d = RIGHT;
                            dir_d   = 1'b1;
                        end else begin
                            state_d = LEFT;
                        end
                    end else if (is_onehot_s && (state_q == RIGHT) && (idx_s == pos_dn_s)) begin
                        pos_d     = idx_s;
                        stall_d   = {STALL_W{1'b0}};
                        stalled_d = 1'b0;
                        if (idx_s == {POS_W{1'b0}}) begin
                            state_d = LEFT;
                            dir_d   = 1'b0;
                            sweep_d = sweep_q + CNT_W'(1'b1);
                        end else begin
                            state_d = RIGHT;
                        end
                    end else begin
                        state_d   = ERROR;
                        err_cnt_d = err_sat_inc(err_cnt_q);
                        stall_d   = {STALL_W{1'b0}};
                        stalled_d = 1'b0;
                    end
                end
                default: begin
                    state_d = SYNC;
                end
            endcase
        end else begin
            last_d = last_q;
        end
        locked_d = (state_d == LEFT) || (state_d == RIGHT);
        err_d    = (state_d == ERROR);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SYNC;
            last_q    <= {WIDTH{1'b0}};
            stall_q   <= {STALL_W{1'b0}};
            pos_q     <= {POS_W{1'b0}};
            dir_q     <= 1'b0;
            locked_q  <= 1'b0;
            sweep_q   <= {CNT_W{1'b0}};
            err_q     <= 1'b0;
            err_cnt_q <= {ERR_CNT_W{1'b0}};
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            stall_q   <= stall_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            locked_q  <= locked_d;
            sweep_q   <= sweep_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            stalled_q <= stalled_d;
        end
    end

    assign pos         = pos_q;
    assign dir         = dir_q;
    assign locked      = locked_q;
    assign sweep_count = sweep_q;
    assign err         = err_q;
    assign err_count   = err_cnt_q;
    assign stalled     = stalled_q;

endmodule

// File: tb/tb_led_sweep_checker.sv
// Directed bench for led_sweep_checker: an abstract sweep model checked every cycle,
// plus hand-computed expectations at key points.
module tb_led_sweep_checker;

    localparam int W      = 16;
    localparam int SLIM   = 8;
    localparam int CW     = 2;

    logic          clk;
    logic          reset;
    logic          en;
    logic [W-1:0]  pattern;
    logic [3:0]    pos;
    logic          dir;
    logic          locked;
    logic [CW-1:0] sweep_count;
    logic          err;
    logic [7:0]    err_count;
    logic          stalled;

    int errors = 0;
    int checks = 0;

    led_sweep_checker #(.WIDTH(W), .STALL_LIMIT(SLIM), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .pattern     (pattern),
        .pos         (pos),
        .dir         (dir),
        .locked      (locked),
        .sweep_count (sweep_count),
        .err         (err),
        .err_count   (err_count),
        .stalled     (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract model: mode 0=hunting, 1=tracking, 2=faulted; direction as +1/-1 step.
    int          m_mode, m_pos, m_dir, m_sweep, m_errc, m_stall, m_target;
    bit          m_stalled;
    logic [W-1:0] m_last;
    logic [W-1:0] m_one;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_pos = 0; m_dir = 0; m_sweep = 0; m_errc = 0;
            m_stall = 0; m_stalled = 1'b0; m_last = '0;
        end else if (en) begin
            m_one = 16'h0001;
            if (m_mode != 1) begin
                m_stall = 0; m_stalled = 1'b0;
                if (pattern == 16'h0001) begin
                    m_mode = 1; m_pos = 0; m_dir = 0;
                end
            end else if (pattern != m_last) begin
                m_target = (m_dir == 0) ? m_pos + 1 : m_pos - 1;
                if ($countones(pattern) == 1 && pattern == (m_one << m_target)) begin
                    if (m_target == 0) m_sweep = (m_sweep + 1) % (1 << CW);
                    m_pos = m_target;
                    if (m_pos == W - 1) m_dir = 1;
                    if (m_pos == 0) m_dir = 0;
                    m_stall = 0; m_stalled = 1'b0;
                end else begin
                    m_mode = 2;
                    m_errc = (m_errc < 255) ? m_errc + 1 : 255;
                    m_stall = 0; m_stalled = 1'b0;
                end
            end else begin
                m_stall = (m_stall < SLIM) ? m_stall + 1 : SLIM;
                m_stalled = (m_stall >= SLIM);
            end
            m_last = pattern;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("pos",         int'(pos),         m_pos);
            chk("dir",         int'(dir),         m_dir);
            chk("locked",      int'(locked),      (m_mode == 1) ? 1 : 0);
            chk("sweep_count", int'(sweep_count), m_sweep);
            chk("err",         int'(err),         (m_mode == 2) ? 1 : 0);
            chk("err_count",   int'(err_count),   m_errc);
            chk("stalled",     int'(stalled),     int'(m_stalled));
        end
    end

    task automatic drive(input logic [W-1:0] p, input int n);
        pattern = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic full_sweep(input int n);
        logic [W-1:0] one;
        one = 16'h0001;
        for (int i = 1; i < W; i++) drive(one << i, n);
        for (int i = W - 2; i >= 0; i--) drive(one << i, n);
    endtask

    initial begin
        logic [W-1:0] one;
        one = 16'h0001;
        reset = 1'b1; en = 1'b1; pattern = '0;
        repeat (2) @(negedge clk);
        chk("rst_locked", int'(locked), 0);
        chk("rst_pos", int'(pos), 0);
        chk("rst_errcnt", int'(err_count), 0);
        reset = 1'b0;

        // Full sweep, one step per 4 clocks.
        drive(16'h0001, 4);
        chk("t1_locked", int'(locked), 1);
        for (int i = 1; i < W; i++) drive(one << i, 4);
        chk("t1_top_pos", int'(pos), 15);
        chk("t1_top_dir", int'(dir), 1);
        for (int i = W - 2; i >= 0; i--) drive(one << i, 4);
        chk("t1_sweeps", int'(sweep_count), 1);
        chk("t1_dir", int'(dir), 0);
        chk("t1_errcnt", int'(err_count), 0);

        // Skipped position, then recovery.
        drive(16'h0002, 1); drive(16'h0004, 1); drive(16'h0008, 1);
        drive(16'h0010, 1); drive(16'h0020, 1);
        chk("t2_pos5", int'(pos), 5);
        drive(16'h0080, 1);
        chk("t2_err", int'(err), 1);
        chk("t2_unlocked", int'(locked), 0);
        chk("t2_errcnt", int'(err_count), 1);
        chk("t2_pos_hold", int'(pos), 5);
        drive(16'h0001, 1);
        chk("t2_relock", int'(locked), 1);
        chk("t2_pos0", int'(pos), 0);

        // Zero then multi-hot: only one error entry; then saturation.
        drive(16'h0000, 1);
        drive(16'h0003, 1);
        chk("t3_single", int'(err_count), 2);
        chk("t3_err", int'(err), 1);
        drive(16'h0001, 1);
        for (int k = 0; k < 256; k++) begin
            drive(16'h0000, 1);
            drive(16'h0001, 1);
        end
        chk("t3_sat", int'(err_count), 255);

        // Stall detection at pos 3.
        drive(16'h0002, 1); drive(16'h0004, 1); drive(16'h0008, 1);
        drive(16'h0008, 7);
        chk("t4_not_yet", int'(stalled), 0);
        drive(16'h0008, 1);
        chk("t4_stalled", int'(stalled), 1);
        chk("t4_locked", int'(locked), 1);
        drive(16'h0010, 1);
        chk("t4_clear", int'(stalled), 0);
        chk("t4_pos4", int'(pos), 4);

        // Change hidden while disabled is judged as one step on re-enable.
        drive(16'h0000, 1); drive(16'h0001, 1); drive(16'h0002, 1); drive(16'h0004, 1);
        en = 1'b0;
        drive(16'h0008, 3); drive(16'h0010, 3);
        chk("t5_hold_pos", int'(pos), 2);
        chk("t5_hold_lock", int'(locked), 1);
        en = 1'b1;
        drive(16'h0010, 1);
        chk("t5_err", int'(err), 1);
        en = 1'b0;
        drive(16'h0001, 3);
        chk("t5_frozen", int'(err), 1);
        en = 1'b1;

        // Build up round trips (count wraps at 4), park at pos 9, then async reset.
        drive(16'h0001, 1);
        full_sweep(1); full_sweep(1);
        chk("t6_sweeps3", int'(sweep_count), 3);
        full_sweep(1);
        chk("t6_wrap", int'(sweep_count), 0);
        full_sweep(1); full_sweep(1); full_sweep(1);
        for (int i = 1; i <= 9; i++) drive(one << i, 1);
        chk("t6_pos9", int'(pos), 9);
        chk("t6_cnt3", int'(sweep_count), 3);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_pos", int'(pos), 0);
        chk("t6_async_cnt", int'(sweep_count), 0);
        chk("t6_async_lock", int'(locked), 0);
        chk("t6_async_errc", int'(err_count), 0);
        @(negedge clk);
        reset = 1'b0;
        drive(16'h0200, 4);
        chk("t6_unlocked", int'(locked), 0);
        chk("t6_no_err", int'(err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
